// File: rtl/fir_coef_loader_pkg.sv
// Shared types and default sizing for the FIR coefficient loader: arbiter
// state encoding, write-buffer entry layout and RAM address widths.
package fir_coef_pkg;

    typedef enum logic {
        ST_ENG = 1'b0,
        ST_WR  = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_FILTERS  = 4;
    localparam int DEF_FILT_AW      = 2;
    localparam int DEF_TAP_AW       = 8;
    localparam int DEF_COEF_W       = 16;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_STARVE_LIMIT = 8;

    // RAM address is {filter, tap}; a buffered entry is {address, coefficient}.
    localparam int DEF_ADDR_W  = DEF_FILT_AW + DEF_TAP_AW;
    localparam int DEF_ENTRY_W = DEF_ADDR_W + DEF_COEF_W;

endpackage

// File: rtl/fir_coef_loader_if.sv
// Bundle of the SPI register-side, FIR-engine and coefficient-RAM signals.
// The loader uses the slave view; the surrounding system drives the master view.
interface fir_coef_loader_if
    import fir_coef_pkg::*;
#(
    parameter int FILT_AW = DEF_FILT_AW,
    parameter int TAP_AW  = DEF_TAP_AW,
    parameter int COEF_W  = DEF_COEF_W
);
    logic                      coef_wr_stb;
    logic [7:0]                coef_lsb;
    logic [7:0]                coef_msb;
    logic [7:0]                filter_sel;
    logic [7:0]                taps_per_filter;
    logic                      tap_ptr_clr;
    logic                      clr_flags;
    logic                      eng_rd_req;
    logic [FILT_AW+TAP_AW-1:0] eng_rd_addr;
    logic                      eng_rd_ready;
    logic                      eng_rd_valid;
    logic [COEF_W-1:0]         eng_rd_data;
    logic                      ram_en;
    logic                      ram_we;
    logic [FILT_AW+TAP_AW-1:0] ram_addr;
    logic [COEF_W-1:0]         ram_wdata;
    logic [COEF_W-1:0]         ram_rdata;
    logic [TAP_AW-1:0]         tap_ptr;
    logic                      busy;
    logic                      overflow;
    logic                      sel_err;

    modport master (
        output coef_wr_stb, coef_lsb, coef_msb, filter_sel, taps_per_filter,
               tap_ptr_clr, clr_flags, eng_rd_req, eng_rd_addr, ram_rdata,
        input  eng_rd_ready, eng_rd_valid, eng_rd_data, ram_en, ram_we,
               ram_addr, ram_wdata, tap_ptr, busy, overflow, sel_err
    );

    modport slave (
        input  coef_wr_stb, coef_lsb, coef_msb, filter_sel, taps_per_filter,
               tap_ptr_clr, clr_flags, eng_rd_req, eng_rd_addr, ram_rdata,
        output eng_rd_ready, eng_rd_valid, eng_rd_data, ram_en, ram_we,
               ram_addr, ram_wdata, tap_ptr, busy, overflow, sel_err
    );

endinterface

// File: rtl/coef_wr_fifo.sv
// Small synchronous FIFO buffering coefficient writes until the RAM is free.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module coef_wr_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[PW-1:0]];

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/fir_coef_loader.sv
// Captures SPI coefficient writes with an auto-incrementing tap pointer and
// arbitrates the single-port coefficient RAM between the FIR engine and those writes.
module fir_coef_loader
    import fir_coef_pkg::*;
#(
    parameter int NUM_FILTERS  = DEF_NUM_FILTERS,
    parameter int FILT_AW      = DEF_FILT_AW,
    parameter int TAP_AW       = DEF_TAP_AW,
    parameter int COEF_W       = DEF_COEF_W,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    fir_coef_loader_if.slave  bus
);
    localparam int ADDR_W  = FILT_AW + TAP_AW;
    localparam int ENTRY_W = ADDR_W + COEF_W;
    localparam int SC_W    = $clog2(STARVE_LIMIT + 1);

    arb_state_e        state_q, state_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic [TAP_AW-1:0] tap_ptr_q, tap_ptr_d;
    logic              overflow_q, overflow_d;
    logic              sel_err_q, sel_err_d;
    logic              rd_valid_q;

    logic [TAP_AW-1:0]  tap_base;
    logic [TAP_AW-1:0]  tap_last;
    logic               sel_bad;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               rd_issue;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head;

    coef_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // Capture path: a same-cycle pointer clear takes effect before the strobe.
    always_comb begin
        tap_base   = bus.tap_ptr_clr ? '0 : tap_ptr_q;
        tap_last   = TAP_AW'(bus.taps_per_filter - 8'd1);
        sel_bad    = (bus.filter_sel >= 8'(NUM_FILTERS));
        push       = bus.coef_wr_stb && !sel_bad && !(full && !pop);
        push_entry = {bus.filter_sel[FILT_AW-1:0], tap_base,
                      COEF_W'({bus.coef_msb, bus.coef_lsb})};
        tap_ptr_d  = tap_base;
        if (push) tap_ptr_d = (tap_base == tap_last) ? '0 : tap_base + 1'b1;

        overflow_d = overflow_q && !bus.clr_flags;
        sel_err_d  = sel_err_q && !bus.clr_flags;
        if (bus.coef_wr_stb && sel_bad)          sel_err_d  = 1'b1;
        if (bus.coef_wr_stb && !sel_bad && full && !pop) overflow_d = 1'b1;
    end

    // Arbiter: engine has priority, but a pending write forces one WR slot
    // after STARVE_LIMIT consecutive engine grants.
    always_comb begin
        state_d          = state_q;
        starve_d         = starve_q;
        pop              = 1'b0;
        rd_issue         = 1'b0;
        bus.eng_rd_ready = 1'b0;
        bus.ram_en       = 1'b0;
        bus.ram_we       = 1'b0;
        bus.ram_addr     = '0;
        bus.ram_wdata    = '0;

        case (state_q)
            ST_ENG: begin
                bus.eng_rd_ready = 1'b1;
                if (bus.eng_rd_req) begin
                    rd_issue     = 1'b1;
                    bus.ram_en   = 1'b1;
                    bus.ram_addr = bus.eng_rd_addr;
                    if (empty) begin
                        starve_d = '0;
                    end else if (starve_q == SC_W'(STARVE_LIMIT - 1)) begin
                        state_d  = ST_WR;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (!empty) begin
                    pop           = 1'b1;
                    bus.ram_en    = 1'b1;
                    bus.ram_we    = 1'b1;
                    bus.ram_addr  = head[ENTRY_W-1 -: ADDR_W];
                    bus.ram_wdata = head[COEF_W-1:0];
                    starve_d      = '0;
                end else begin
                    starve_d = '0;
                end
            end
            ST_WR: begin
                pop           = 1'b1;
                bus.ram_en    = 1'b1;
                bus.ram_we    = 1'b1;
                bus.ram_addr  = head[ENTRY_W-1 -: ADDR_W];
                bus.ram_wdata = head[COEF_W-1:0];
                starve_d      = '0;
                state_d       = ST_ENG;
            end
            default: state_d = ST_ENG;
        endcase

        if (reset) begin
            pop              = 1'b0;
            rd_issue         = 1'b0;
            bus.eng_rd_ready = 1'b0;
            bus.ram_en       = 1'b0;
            bus.ram_we       = 1'b0;
            bus.ram_addr     = '0;
            bus.ram_wdata    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ENG;
            starve_q   <= '0;
            tap_ptr_q  <= '0;
            overflow_q <= 1'b0;
            sel_err_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            tap_ptr_q  <= tap_ptr_d;
            overflow_q <= overflow_d;
            sel_err_q  <= sel_err_d;
            rd_valid_q <= rd_issue;
        end
    end

    assign bus.eng_rd_valid = rd_valid_q && !reset;
    assign bus.eng_rd_data  = bus.eng_rd_valid ? bus.ram_rdata : '0;
    assign bus.tap_ptr      = tap_ptr_q;
    assign bus.busy         = !empty;
    assign bus.overflow     = overflow_q;
    assign bus.sel_err      = sel_err_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Self-checking bench: a behavioural model of capture and arbitration predicts
// every RAM op; queued write entries and read returns are compared as they appear.
module tb_fir_coef_loader;
    import fir_coef_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    localparam int NF    = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fir_coef_loader_if bus ();

    fir_coef_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Coefficient RAM: single port, one-cycle read latency.
    logic [15:0] mem [0:1023];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state; m_q is the write scoreboard, rd_q the read-return scoreboard.
    int          m_state = 0;
    int          m_starve = 0;
    logic [25:0] m_q[$];
    logic [15:0] rd_q[$];
    logic [7:0]  m_tap = 8'd0;
    bit          m_ovf = 0, m_sel = 0, m_vld = 0, m_init = 0;

    int          occ;
    bit          e_rd, e_wr, e_v, sel_bad, acc;
    logic [25:0] ent;
    logic [15:0] rexp;
    logic [7:0]  base, last;

    always @(negedge clk) begin
        occ  = m_q.size();
        e_rd = !reset && (m_state == 0) && bus.eng_rd_req;
        e_wr = !reset && (((m_state == 0) && !bus.eng_rd_req && occ != 0) || (m_state == 1));
        e_v  = !reset && m_vld;
        if (m_init) begin
            check("eng_rd_ready", bus.eng_rd_ready, !reset && (m_state == 0));
            check("ram_en", bus.ram_en, e_rd || e_wr);
            check("ram_we", bus.ram_we, e_wr);
            if (e_rd) check("rd_addr", bus.ram_addr, bus.eng_rd_addr);
            if (e_wr && occ != 0) begin
                ent = m_q.pop_front();
                check("wr_addr", bus.ram_addr, ent[25:16]);
                check("wr_data", bus.ram_wdata, ent[15:0]);
            end
            check("eng_rd_valid", bus.eng_rd_valid, e_v);
            if (m_vld && rd_q.size() != 0) rexp = rd_q.pop_front();
            check("eng_rd_data", bus.eng_rd_data, e_v ? rexp : 16'h0);
            check("tap_ptr", bus.tap_ptr, m_tap);
            check("busy", bus.busy, occ != 0);
            check("overflow", bus.overflow, m_ovf);
            check("sel_err", bus.sel_err, m_sel);
        end
        if (reset) begin
            m_q.delete(); rd_q.delete();
            m_state = 0; m_starve = 0; m_tap = 0;
            m_ovf = 0; m_sel = 0; m_vld = 0; m_init = 1;
        end else begin
            sel_bad = bus.filter_sel >= 8'(NF);
            acc  = bus.coef_wr_stb && !sel_bad && !(occ == DEPTH && !e_wr);
            base = bus.tap_ptr_clr ? 8'd0 : m_tap;
            last = bus.taps_per_filter - 8'd1;
            if (acc) begin
                m_q.push_back({bus.filter_sel[1:0], base, bus.coef_msb, bus.coef_lsb});
                m_tap = (base == last) ? 8'd0 : base + 8'd1;
            end else begin
                m_tap = base;
            end
            if (bus.clr_flags) begin m_ovf = 0; m_sel = 0; end
            if (bus.coef_wr_stb && sel_bad) m_sel = 1;
            if (bus.coef_wr_stb && !sel_bad && occ == DEPTH && !e_wr) m_ovf = 1;
            if (e_rd) rd_q.push_back(mem[bus.eng_rd_addr]);
            m_vld = e_rd;
            if (m_state == 1) begin
                m_state = 0; m_starve = 0;
            end else if (bus.eng_rd_req && occ != 0) begin
                if (m_starve == LIMIT - 1) begin m_state = 1; m_starve = 0; end
                else m_starve++;
            end else begin
                m_starve = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit stb, input logic [7:0] sel, input logic [15:0] coef,
                         input bit clr, input bit cf);
        bus.coef_wr_stb = stb;
        bus.filter_sel  = sel;
        bus.coef_msb    = coef[15:8];
        bus.coef_lsb    = coef[7:0];
        bus.tap_ptr_clr = clr;
        bus.clr_flags   = cf;
        tick();
        bus.coef_wr_stb = 1'b0;
        bus.tap_ptr_clr = 1'b0;
        bus.clr_flags   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int lows;
    int low_at[$];

    initial begin
        bus.coef_wr_stb = 0; bus.coef_lsb = 0; bus.coef_msb = 0; bus.filter_sel = 0;
        bus.taps_per_filter = 8'd4; bus.tap_ptr_clr = 0; bus.clr_flags = 0;
        bus.eng_rd_req = 0; bus.eng_rd_addr = '0;

        // Reset state
        repeat (3) tick();
        check("rst_tap", bus.tap_ptr, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.eng_rd_ready, 0);
        check("rst_ram_en", bus.ram_en, 0);
        check("rst_valid", bus.eng_rd_valid, 0);
        check("rst_flags", {bus.overflow, bus.sel_err}, 0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", bus.eng_rd_ready, 1);

        // Basic writes, engine idle
        for (int i = 1; i <= 5; i++) drive(1, 8'd1, {i[7:0], i[7:0]}, 0, 0);
        repeat (3) tick();
        check("basic_tap", bus.tap_ptr, 1);
        check("basic_mem100", mem[10'h100], 16'h0505);
        check("basic_mem101", mem[10'h101], 16'h0202);
        check("basic_mem103", mem[10'h103], 16'h0404);

        // Pointer clear beats the same-cycle strobe
        drive(1, 8'd1, 16'h1111, 0, 0);
        drive(1, 8'd1, 16'h2222, 0, 0);
        check("clr_pre_tap", bus.tap_ptr, 3);
        drive(1, 8'd1, 16'hBEEF, 1, 0);
        repeat (2) tick();
        check("clr_tap", bus.tap_ptr, 1);
        check("clr_mem100", mem[10'h100], 16'hBEEF);

        // Bad filter select
        drive(1, 8'd4, 16'h1234, 0, 0);
        check("sel_err_set", bus.sel_err, 1);
        check("sel_tap", bus.tap_ptr, 1);
        check("sel_busy", bus.busy, 0);
        drive(0, 8'd0, 16'h0, 0, 1);
        check("sel_err_clr", bus.sel_err, 0);
        drive(1, 8'd5, 16'h1234, 0, 1);
        check("sel_set_wins", bus.sel_err, 1);
        drive(0, 8'd0, 16'h0, 0, 1);
        tick();

        // Starvation guard with the engine saturating
        lows = 0;
        for (int k = 0; k < 24; k++) begin
            bus.eng_rd_req  = 1'b1;
            bus.eng_rd_addr = 10'h100 + 10'(k % 4);
            bus.coef_wr_stb = (k < 2);
            bus.filter_sel  = 8'd2;
            {bus.coef_msb, bus.coef_lsb} = (k == 0) ? 16'hA1A1 : 16'hB2B2;
            #1;
            if (!bus.eng_rd_ready) begin lows++; low_at.push_back(k); end
            tick();
        end
        bus.coef_wr_stb = 0; bus.eng_rd_req = 0;
        repeat (2) tick();
        check("starve_lows", lows, 2);
        check("starve_first", (low_at.size() > 0) ? low_at[0] : -1, 9);
        check("starve_second", (low_at.size() > 1) ? low_at[1] : -1, 18);
        check("starve_mem201", mem[10'h201], 16'hA1A1);
        check("starve_mem202", mem[10'h202], 16'hB2B2);

        // Overflow with the engine saturating
        bus.taps_per_filter = 8'd8;
        repeat (2) tick();
        bus.eng_rd_req = 1'b1;
        bus.eng_rd_addr = 10'h101;
        for (int k = 0; k < 6; k++) drive(1, 8'd3, 16'h3000 + 16'(k), k == 0, 0);
        check("ovf_flag", bus.overflow, 1);
        check("ovf_tap", bus.tap_ptr, 4);
        check("ovf_busy", bus.busy, 1);
        repeat (40) tick();
        bus.eng_rd_req = 1'b0;
        repeat (3) tick();
        check("ovf_drained", bus.busy, 0);
        check("ovf_mem300", mem[10'h300], 16'h3000);
        check("ovf_mem303", mem[10'h303], 16'h3003);
        drive(0, 8'd0, 16'h0, 0, 1);
        check("ovf_clr", bus.overflow, 0);

        // Reset with entries pending and a read in flight
        bus.eng_rd_req = 1'b1;
        bus.eng_rd_addr = 10'h100;
        for (int k = 0; k < 3; k++) drive(1, 8'd0, 16'h4000 + 16'(k), 0, 0);
        check("mid_busy_pre", bus.busy, 1);
        reset = 1'b1;
        #1;
        check("mid_valid_sup", bus.eng_rd_valid, 0);
        check("mid_ram_en_rst", bus.ram_en, 0);
        tick();
        reset = 1'b0;
        bus.eng_rd_req = 1'b0;
        #1;
        check("mid_busy", bus.busy, 0);
        check("mid_valid", bus.eng_rd_valid, 0);
        check("mid_tap", bus.tap_ptr, 0);
        check("mid_ram_en", bus.ram_en, 0);
        repeat (4) tick();
        check("mid_busy_late", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_coef_loader.md
Name: fir_coef_loader

Overview:
Sequences FIR coefficient writes arriving from the SPI register file into the shared single-port coefficient RAM, with an auto-incrementing tap pointer per filter. It arbitrates the same RAM between this SPI write path and the FIR engine's coefficient reads. The engine has priority, and a starvation guard lets writes through. It sits between the SPI register block (coef_wr_stb, coefficient LSB/MSB, filter select, taps per filter) and the FIR datapath/coefficient RAM.

Parameters:
NUM_FILTERS, 4, number of filters in the RAM; valid filter_sel range is 0..NUM_FILTERS-1
FILT_AW, 2, filter-index bits of the RAM address
TAP_AW, 8, tap-index bits of the RAM address
COEF_W, 16, coefficient width, {msb,lsb}
FIFO_DEPTH, 4, write-buffer entries (power of 2)
STARVE_LIMIT, 8, consecutive engine-granted cycles allowed while writes are pending

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
coef_wr_stb  in  1  one-cycle pulse: coefficient MSB register written, so capture a coefficient
coef_lsb  in  8  coefficient low byte
coef_msb  in  8  coefficient high byte
filter_sel  in  8  target filter index
taps_per_filter  in  8  taps per filter; 0 means 256
tap_ptr_clr  in  1  pulse: reset tap pointer to 0 (driven on a FILTER_SEL write)
clr_flags  in  1  pulse: clear sticky error flags
eng_rd_req  in  1  engine coefficient read request
eng_rd_addr  in  FILT_AW+TAP_AW  engine read address {filter,tap}
eng_rd_ready  out  1  engine request accepted this cycle
eng_rd_valid  out  1  eng_rd_data valid
eng_rd_data  out  COEF_W  read coefficient
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  FILT_AW+TAP_AW  RAM address
ram_wdata  out  COEF_W  RAM write data
ram_rdata  in  COEF_W  RAM read data, 1-cycle latency
tap_ptr  out  TAP_AW  next tap index to be written
busy  out  1  FIFO non-empty
overflow  out  1  sticky: strobe dropped because the FIFO was full
sel_err  out  1  sticky: strobe dropped because filter_sel >= NUM_FILTERS

Behaviour:
- Reset (synchronous): FIFO empty, tap_ptr=0, FSM=ENG, starve_cnt=0. All outputs are 0 (eng_rd_data=0).
- Capture on coef_wr_stb:
  - Push {filter_sel[FILT_AW-1:0], tap_ptr, coef_msb, coef_lsb}.
  - Then tap_ptr advances: wraps to 0 when tap_ptr == taps_per_filter-1 (255 when taps_per_filter=0), otherwise +1.
- tap_ptr_clr and coef_wr_stb in the same cycle: the clear applies first. The entry uses tap 0 and tap_ptr ends at 1.
- Dropped strobes:
  - filter_sel >= NUM_FILTERS: no push, sel_err=1, tap_ptr unchanged.
  - FIFO full with no pop in the same cycle: no push, overflow=1, tap_ptr unchanged. Push and pop in the same cycle while full is accepted.
- clr_flags clears both sticky flags. A set event in the same cycle wins over the clear.
- Arbiter FSM:
  - ENG:
    - eng_rd_ready=1. An engine read is issued when eng_rd_req: ram_en=1, ram_we=0, ram_addr=eng_rd_addr.
    - When eng_rd_req=0 and the FIFO is non-empty: pop and write (ram_en=1, ram_we=1).
    - starve_cnt increments on each granted engine cycle while the FIFO is non-empty. It resets to 0 when the FIFO is empty or a write is issued.
    - When starve_cnt == STARVE_LIMIT-1 and an engine grant occurs with the FIFO non-empty, go to WR.
  - WR (exactly one cycle):
    - eng_rd_ready=0; pop and write; starve_cnt=0; return to ENG.
- Read return: eng_rd_valid is asserted in cycle N+1 for an accepted read in cycle N. eng_rd_data = ram_rdata, registered out to a defined 0 when not valid.
- RAM writes are issued strictly in FIFO order. At most one RAM op per cycle.
- Reset mid-operation: pending FIFO entries are discarded and an in-flight eng_rd_valid is suppressed.

Decomposition:
- Package fir_coef_pkg holds:
  - the FSM state encoding (ENG, WR);
  - the entry field widths and the address-concat localparam;
  - the default NUM_FILTERS, COEF_W and STARVE_LIMIT.
- One sub-module, coef_wr_fifo: synchronous FIFO with push/pop/full/empty and a width parameter. The top level holds the tap counter, flags and arbiter FSM.

Test Plan:
- Basic writes: taps_per_filter=4, filter_sel=1, 5 strobes with coefs 0x0101..0x0505, engine idle -> RAM writes to addr 0x100,0x101,0x102,0x103,0x100, each one cycle after capture; final tap_ptr=1.
- Clear priority: tap_ptr=3, tap_ptr_clr and strobe in the same cycle with coef 0xBEEF -> write to {filt,0}; tap_ptr=1.
- Bad select: filter_sel=4 with NUM_FILTERS=4 -> no RAM write, sel_err=1, tap_ptr unchanged; clr_flags -> sel_err=0.
- Starvation guard: eng_rd_req held high continuously, 2 strobes -> engine reads accepted 8 cycles, then eng_rd_ready=0 for one cycle with a write issued, repeated for the second entry; eng_rd_valid follows each accepted read by 1 cycle with the correct data.
- Overflow: engine saturating, 6 strobes in 6 cycles with FIFO_DEPTH=4 -> 4 entries buffered, then overflow=1; tap_ptr advanced only 4 times (or 5 if a forced write popped in time, checked against the model).
- Mid-operation reset: reset asserted with 3 entries pending and a read in flight -> no further RAM ops, busy=0, eng_rd_valid=0, tap_ptr=0 the next cycle.
